i2c_bus_cond_gen: RTL and testbench

//  Parametrised I2C bus-condition generator for the master datapath: produces START, repeated

---
 rtl/i2c_bus_cond_gen.sv | 164 ++++++++++++++++
 tb/tb_i2c_bus_cond_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_cond_gen.sv
// I2C bus-condition generator: START, repeated START and STOP with setup/hold timing and SCL stretch.
// Optional feature macro: I2C_COND_ARB_CHECK_EN (SDA arbitration-loss abort during timed waits).
module i2c_bus_cond_gen #(
    parameter int CNT_W = 8,
    parameter int T_SU  = 4,
    parameter int T_HD  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_cmd,
    input  logic       i_SCL,
    input  logic       i_SDA,
    output logic       o_SCL,
    output logic       o_SDA,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_arb_lost,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SDA_PREP = 3'd1,
        SCL_REL  = 3'd2,
        SU_WAIT  = 3'd3,
        SDA_EDGE = 3'd4,
        HD_WAIT  = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_START  = 2'b01;
    localparam logic [1:0] CMD_STOP   = 2'b11;
    localparam logic [CNT_W-1:0] SU_LOAD = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] HD_LOAD = CNT_W'(T_HD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             scl_d, sda_d, busy_d, done_d, arb_d;
    logic             stretch, cnt_zero;

    // Handshake: i_en/i_cmd is a request taken only on an edge where o_busy is low;
    // each accepted non-NOP command is closed by exactly one o_done (or o_arb_lost) pulse.
    assign stretch   = o_SCL && !i_SCL;
    assign cnt_zero  = (cnt_q == '0);
    assign dbg_state = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stop_q     <= 1'b0;
            o_SCL      <= 1'b1;
            o_SDA      <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_arb_lost <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stop_q     <= stop_d;
            o_SCL      <= scl_d;
            o_SDA      <= sda_d;
            o_busy     <= busy_d;
            o_done     <= done_d;
            o_arb_lost <= arb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        scl_d   = o_SCL;
        sda_d   = o_SDA;
        busy_d  = o_busy;
        done_d  = 1'b0;
        arb_d   = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (i_en && i_cmd != CMD_NOP) begin
                    busy_d  = 1'b1;
                    stop_d  = (i_cmd == CMD_STOP);
                    cnt_d   = SU_LOAD;
                    if (o_SCL && i_cmd == CMD_START) begin
                        state_d = SU_WAIT;
                        sda_d   = 1'b1;
                    end else if (o_SCL && i_cmd == CMD_STOP) begin
                        state_d = SU_WAIT;
                        sda_d   = 1'b0;
                    end else begin
                        // SCL is (or goes) low first so SDA may move without forming a condition
                        state_d = SDA_PREP;
                        scl_d   = 1'b0;
                        sda_d   = (i_cmd != CMD_STOP);
                    end
                end
            end
            SDA_PREP: begin
                if (cnt_zero) begin
                    state_d = SCL_REL;
                    scl_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SCL_REL: begin
                state_d = SU_WAIT;
                cnt_d   = SU_LOAD;
            end
            SU_WAIT: begin
                if (!stretch) begin
                    if (cnt_zero) begin
                        state_d = SDA_EDGE;
                        sda_d   = stop_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            SDA_EDGE: begin
                state_d = HD_WAIT;
                cnt_d   = HD_LOAD;
            end
            HD_WAIT: begin
                if (!stretch) begin
                    if (cnt_zero) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (!stop_q) scl_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
`ifdef I2C_COND_ARB_CHECK_EN
        // Another master pulled SDA low while we released it: back off completely
        if ((state_q == SU_WAIT || state_q == HD_WAIT) && o_SDA && !i_SDA && i_SCL) begin
            state_d = IDLE;
            cnt_d   = '0;
            scl_d   = 1'b1;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            arb_d   = 1'b1;
        end
`endif
    end

`ifndef I2C_COND_ARB_CHECK_EN
    logic unused_sda;
    assign unused_sda = i_SDA;
`endif

endmodule

// File: tb/tb_i2c_bus_cond_gen.sv
// Randomized scoreboard bench for i2c_bus_cond_gen: expected done pulses and SCL-high SDA edges
// are queued by a bus-level timing model and popped by an independent monitor.
module tb_i2c_bus_cond_gen;
    localparam int T_SU = 4;
    localparam int T_HD = 4;
    localparam logic [1:0] C_NOP = 2'b00, C_START = 2'b01, C_RSTART = 2'b10, C_STOP = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       stretch_hold = 1'b0;
    logic       scl_in, sda_in;
    logic       scl, sda, busy, done, arb;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic model_scl = 1'b1;

    logic [33:0] exp_done_q[$];
    logic [32:0] exp_edge_q[$];
    logic [33:0] de;
    logic [32:0] ee;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;

    // Pad readback: a slave may hold SCL low; SDA reads back what we drive
    assign scl_in = scl & ~stretch_hold;
    assign sda_in = sda;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_bus_cond_gen #(.CNT_W(8), .T_SU(T_SU), .T_HD(T_HD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cmd(cmd),
        .i_SCL(scl_in), .i_SDA(sda_in),
        .o_SCL(scl), .o_SDA(sda), .o_busy(busy), .o_done(done),
        .o_arb_lost(arb), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a done pulse or an SDA edge under high SCL
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl = 1'b1;
            prev_sda = 1'b1;
        end else begin
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    de = exp_done_q.pop_front();
                    check("done_cycle", cyc, de[33:2]);
                    check("done_lines", {scl, sda}, de[1:0]);
                    check("done_busy", busy, 0);
                    check("done_arb", arb, 0);
                end
            end
            if (prev_scl && scl && sda !== prev_sda) begin
                if (exp_edge_q.size() == 0) begin
                    check("edge_unexpected", 1, 0);
                end else begin
                    ee = exp_edge_q.pop_front();
                    check("edge_cycle", cyc, ee[32:1]);
                    check("edge_value", sda, ee[0]);
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // Issue one command at a negedge; the model derives bus timing from phase lengths:
    // optional SCL-low preparation (T_SU + 1 to release SCL), setup T_SU plus stretch, 1 edge cycle, hold T_HD.
    task automatic issue(input logic [1:0] c, input int n_str, input bit poke);
        int a, prep, su_entry, done_c;
        a = cyc + 1;
        if (c == C_NOP) begin
            en = 1'b1; cmd = C_NOP;
            @(negedge clk);
            en = 1'b0;
            repeat (2) @(negedge clk);
            return;
        end
        prep     = (c == C_RSTART || model_scl == 1'b0) ? T_SU + 1 : 0;
        su_entry = a + prep;
        done_c   = su_entry + T_SU + n_str + 1 + T_HD;
        if (c == C_STOP && model_scl) exp_edge_q.push_back({32'(a), 1'b0});
        exp_edge_q.push_back({32'(su_entry + T_SU + n_str), (c == C_STOP)});
        exp_done_q.push_back({32'(done_c), (c == C_STOP) ? 2'b11 : 2'b00});
        model_scl = (c == C_STOP);
        en = 1'b1; cmd = c;
        @(negedge clk);
        en = 1'b0; cmd = C_NOP;
        while (cyc < done_c) begin
            if (n_str > 0 && cyc == su_entry) stretch_hold = 1'b1;
            if (n_str > 0 && cyc == su_entry + n_str) stretch_hold = 1'b0;
            if (poke) begin
                en  = 1'($urandom_range(0, 1));
                cmd = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        stretch_hold = 1'b0;
        en = 1'b0; cmd = C_NOP;
    endtask

    initial begin
        en = 1'b1; cmd = C_START;
        repeat (3) begin
            @(negedge clk);
            check("rst_scl", scl, 1);
            check("rst_sda", sda, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        en = 1'b0; cmd = C_NOP;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(C_START, 0, 0);
        issue(C_RSTART, 0, 0);
        issue(C_STOP, 0, 0);
        check("after_stop_busy", busy, 0);
        issue(C_START, 0, 0);
        issue(C_STOP, 10, 0);
        issue(C_NOP, 0, 0);
        issue(C_START, 0, 1);
        issue(C_STOP, 3, 1);
        issue(C_STOP, 0, 0);
        issue(C_RSTART, 2, 0);
        issue(C_STOP, 0, 1);

        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        issue(C_START, 0, 0);
        en = 1'b1; cmd = C_STOP;
        @(negedge clk);
        en = 1'b0; cmd = C_NOP;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        check("abort_busy", busy, 0);
        model_scl = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) @(negedge clk);
        check("end_done_queue", exp_done_q.size(), 0);
        check("end_edge_queue", exp_edge_q.size(), 0);
        check("end_scl", scl, 1);
        check("end_sda", sda, 1);
        check("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
